// File: rtl/usb_rx_packet_fsm.sv
// usb_rx_packet_fsm: USB packet receive controller; checks SYNC/PID and forwards DATA payload with the CRC16 stripped.
// Define USB_RX_CRC16_CHECK_EN to reject DATA packets whose CRC16 residual is wrong.
module usb_rx_packet_fsm #(
    parameter int         MAX_DATA_BYTES = 64,
    parameter logic [7:0] SYNC_BYTE      = 8'h80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_byte_valid,
    input  logic [7:0] rx_byte,
    input  logic       rx_eop,
    input  logic       rx_bit_error,
    input  logic       buffer_full,
    output logic [3:0] RX_Packet,
    output logic       rx_packet_valid,
    output logic       store_rx_data,
    output logic [7:0] rx_data,
    output logic [6:0] byte_count,
    output logic       RX_Transfer_Active,
    output logic       RX_Error,
    output logic [2:0] out_state_RX
);
    typedef enum logic [2:0] {
        IDLE_RX  = 3'd0,
        PID_RX   = 3'd1,
        TOKEN_RX = 3'd2,
        DATA_RX  = 3'd3,
        EOP_RX   = 3'd4,
        ERROR_RX = 3'd5,
        DONE_RX  = 3'd6
    } state_t;

    state_t     state;
    logic [7:0] hold0, hold1;
    logic [1:0] hcnt;
    logic       tok_cnt;
    logic [1:0] kind;
    logic       crc_ok;

    // PID class: 0 illegal, 1 token, 2 data, 3 handshake
    assign kind = (rx_byte[7:4] != ~rx_byte[3:0]) ? 2'd0
                : (rx_byte[3:0] inside {4'b0001, 4'b1001}) ? 2'd1
                : (rx_byte[3:0] inside {4'b0011, 4'b1011}) ? 2'd2
                : (rx_byte[3:0] inside {4'b0010, 4'b1010, 4'b1110}) ? 2'd3 : 2'd0;

`ifdef USB_RX_CRC16_CHECK_EN
    logic [15:0] crc, crc_next;

    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++)
            crc_next = {crc_next[14:0], 1'b0} ^ ((crc_next[15] ^ rx_byte[i]) ? 16'h8005 : 16'h0000);
    end

    always_ff @(posedge clk or posedge rst)
        if (rst)
            crc <= '0;
        else if (rx_byte_valid && state == PID_RX)
            crc <= 16'hFFFF;
        else if (rx_byte_valid && state == DATA_RX)
            crc <= crc_next;

    assign crc_ok = crc == 16'h800D;
`else
    assign crc_ok = 1'b1;
`endif

    assign out_state_RX       = state;
    assign RX_Error           = state == ERROR_RX;
    assign RX_Transfer_Active = state != IDLE_RX && state != ERROR_RX;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE_RX;
            RX_Packet       <= '0;
            rx_packet_valid <= 1'b0;
            store_rx_data   <= 1'b0;
            rx_data         <= '0;
            byte_count      <= '0;
            hold0           <= '0;
            hold1           <= '0;
            hcnt            <= '0;
            tok_cnt         <= 1'b0;
        end else begin
            store_rx_data   <= 1'b0;
            rx_packet_valid <= 1'b0;
            if (state != IDLE_RX && rx_bit_error)
                state <= ERROR_RX;
            else if (rx_byte_valid && rx_eop)
                state <= ERROR_RX;
            else begin
                case (state)
                    IDLE_RX:
                        if (rx_byte_valid) begin
                            state <= (rx_byte == SYNC_BYTE) ? PID_RX : ERROR_RX;
                            if (rx_byte == SYNC_BYTE)
                                byte_count <= '0;
                        end
                    PID_RX:
                        if (rx_eop)
                            state <= ERROR_RX;
                        else if (rx_byte_valid) begin
                            state   <= kind == 2'd1 ? TOKEN_RX : kind == 2'd2 ? DATA_RX
                                     : kind == 2'd3 ? EOP_RX : ERROR_RX;
                            hcnt    <= '0;
                            tok_cnt <= 1'b0;
                            if (kind != 2'd0)
                                RX_Packet <= rx_byte[3:0];
                        end
                    TOKEN_RX:
                        if (rx_eop)
                            state <= ERROR_RX;
                        else if (rx_byte_valid) begin
                            tok_cnt <= 1'b1;
                            if (tok_cnt)
                                state <= EOP_RX;
                        end
                    DATA_RX:
                        if (rx_eop) begin
                            state           <= (hcnt == 2'd2 && crc_ok) ? DONE_RX : ERROR_RX;
                            rx_packet_valid <= hcnt == 2'd2 && crc_ok;
                        end else if (rx_byte_valid) begin
                            // the two newest bytes are held back: at EOP they are the CRC16
                            if (hcnt == 2'd2) begin
                                if (buffer_full || byte_count == 7'(MAX_DATA_BYTES))
                                    state <= ERROR_RX;
                                else begin
                                    rx_data       <= hold1;
                                    store_rx_data <= 1'b1;
                                    byte_count    <= byte_count + 7'd1;
                                end
                            end
                            hold1 <= hold0;
                            hold0 <= rx_byte;
                            hcnt  <= (hcnt == 2'd2) ? 2'd2 : hcnt + 2'd1;
                        end
                    EOP_RX:
                        if (rx_eop) begin
                            state           <= DONE_RX;
                            rx_packet_valid <= 1'b1;
                        end else if (rx_byte_valid)
                            state <= ERROR_RX;
                    DONE_RX:
                        state <= IDLE_RX;
                    ERROR_RX:
                        if (rx_eop)
                            state <= IDLE_RX;
                    default:
                        state <= IDLE_RX;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usb_rx_packet_fsm.sv
// tb_usb_rx_packet_fsm: packet-level reference model with per-cycle output comparison plus directed literal checks.
module tb_usb_rx_packet_fsm;
    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic       st;
        logic [7:0] d;
        logic       v;
        logic       err;
        logic       act;
        logic [6:0] cnt;
        logic [3:0] pid;
    } obs_t;

    localparam int MAX = 64;

    logic       clk = 0, rst = 1;
    logic       rx_byte_valid = 0, rx_eop = 0, rx_bit_error = 0, buffer_full = 0;
    logic [7:0] rx_byte = 0;
    logic [3:0] RX_Packet;
    logic       rx_packet_valid, store_rx_data, RX_Transfer_Active, RX_Error;
    logic [7:0] rx_data;
    logic [6:0] byte_count;
    logic [2:0] out_state_RX;
    logic [22:0] dut_o;

    obs_t m = '0, nxt = '0, cur = '0;
    int   checks = 0, passed = 0, vcount = 0;
    bq_t  got_q;

    usb_rx_packet_fsm dut (
        .clk(clk), .rst(rst), .rx_byte_valid(rx_byte_valid), .rx_byte(rx_byte),
        .rx_eop(rx_eop), .rx_bit_error(rx_bit_error), .buffer_full(buffer_full),
        .RX_Packet(RX_Packet), .rx_packet_valid(rx_packet_valid), .store_rx_data(store_rx_data),
        .rx_data(rx_data), .byte_count(byte_count), .RX_Transfer_Active(RX_Transfer_Active),
        .RX_Error(RX_Error), .out_state_RX(out_state_RX)
    );

    always #5 clk = ~clk;

    assign dut_o = {store_rx_data, store_rx_data ? rx_data : 8'h00, rx_packet_valid,
                    RX_Error, RX_Transfer_Active, byte_count, RX_Packet};

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    endtask

    // expectation written by the driver applies to the outputs after the following edge
    initial forever begin
        @(posedge clk);
        cur = nxt;
        @(negedge clk);
        check("cycle", 32'(dut_o), 32'(cur));
        if (store_rx_data) got_q.push_back(rx_data);
        if (rx_packet_valid) vcount++;
    end

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    function automatic bq_t crc_bytes(input bq_t p);
        logic [15:0] c;
        bq_t r;
        c = 16'hFFFF;
        foreach (p[j])
            for (int i = 0; i < 8; i++)
                c = {c[14:0], 1'b0} ^ ((c[15] ^ p[j][i]) ? 16'h8005 : 16'h0000);
        c = ~c;
        r.push_back(rev8(c[15:8]));
        r.push_back(rev8(c[7:0]));
        return r;
    endfunction

    function automatic bq_t mk_data(input logic [7:0] pid, input bq_t pl);
        bq_t q, c;
        c = crc_bytes(pl);
        q.push_back(8'h80);
        q.push_back(pid);
        foreach (pl[i]) q.push_back(pl[i]);
        foreach (c[i]) q.push_back(c[i]);
        return q;
    endfunction

    function automatic int pid_kind(input logic [7:0] b);
        if (b[7:4] != ~b[3:0]) return 0;
        case (b[3:0])
            4'h1, 4'h9:       return 1;
            4'h3, 4'hB:       return 2;
            4'h2, 4'hA, 4'hE: return 3;
            default:          return 0;
        endcase
    endfunction

    task automatic cyc(input logic v, input logic [7:0] b, input logic e, input logic bf, input logic be);
        rx_byte_valid = v; rx_byte = b; rx_eop = e; buffer_full = bf; rx_bit_error = be;
        nxt = m;
        m.st = 0; m.v = 0; m.d = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(0, 8'h00, 0, 1'($urandom_range(0, 1)), 0);
    endtask

    // fail = index of the byte that breaks the packet, n for a failing EOP, -1 for a good packet
    task automatic send_pkt(input bq_t q, input int bf_idx);
        int   n, fail, kind;
        logic emit;
        n = q.size(); fail = -1; kind = 0;
        if (q[0] != 8'h80) fail = 0;
        else if (n < 2) fail = n;
        else begin
            kind = pid_kind(q[1]);
            if (kind == 0) fail = 1;
            else if (kind == 1) fail = n < 4 ? n : n > 4 ? 4 : -1;
            else if (kind == 3) fail = n > 2 ? 2 : -1;
            else if (n < 4) fail = n;
            else begin
                for (int i = 4; i < n && fail < 0; i++)
                    if (i == bf_idx || i - 4 >= MAX) fail = i;
`ifdef USB_RX_CRC16_CHECK_EN
                if (fail < 0) begin
                    bq_t pl, c;
                    for (int i = 2; i < n - 2; i++) pl.push_back(q[i]);
                    c = crc_bytes(pl);
                    if (c[0] != q[n-2] || c[1] != q[n-1]) fail = n;
                end
`endif
            end
        end
        for (int i = 0; i < n; i++) begin
            emit = kind == 2 && i >= 4;
            if (fail < 0 || i < fail) begin
                if (i == 0) begin m.cnt = 0; m.act = 1; end
                if (i == 1) m.pid = q[1][3:0];
                if (emit) begin m.st = 1; m.d = q[i-2]; m.cnt = m.cnt + 7'd1; end
            end else if (i == fail) begin
                m.err = 1; m.act = 0;
            end
            cyc(1, q[i], 0, i == bf_idx || (!emit && $urandom_range(0, 1) == 1), 0);
            idle($urandom_range(0, 2));
        end
        if (fail < 0) begin
            m.v = 1;
            cyc(0, 8'h00, 1, 0, 0);
            m.act = 0;
            idle(1);
        end else if (fail == n) begin
            m.err = 1; m.act = 0;
            cyc(0, 8'h00, 1, 0, 0);
            idle($urandom_range(0, 2));
            m.err = 0;
            cyc(0, 8'h00, 1, 0, 0);
        end else begin
            m.err = 0;
            cyc(0, 8'h00, 1, 0, 0);
        end
        idle($urandom_range(1, 3));
    endtask

    initial begin
        bq_t q, pl, zc;
        int  v0, t, bf;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("reset_state", {out_state_RX, RX_Transfer_Active, RX_Error}, 0);
        idle(2);

        got_q = {}; v0 = vcount;
        q = {8'h80, 8'hD2};
        send_pkt(q, -1);
        check("ack_pid", RX_Packet, 4'b0010);
        check("ack_valid", vcount - v0, 1);
        check("ack_no_store", got_q.size(), 0);

        got_q = {}; v0 = vcount;
        pl = {8'h01, 8'h02, 8'h03};
        q = mk_data(8'hC3, pl);
        send_pkt(q, -1);
        check("d0_stores", got_q.size(), 3);
        for (int i = 0; i < got_q.size() && i < 3; i++) check("d0_data", got_q[i], i + 1);
        check("d0_count", byte_count, 3);
        check("d0_pid", RX_Packet, 4'h3);
        check("d0_valid", vcount - v0, 1);

        m.cnt = 0; m.act = 1;
        cyc(1, 8'h80, 0, 0, 0);
        m.err = 1; m.act = 0;
        cyc(1, 8'h33, 0, 0, 0);
        idle(1);
        check("badpid_state", out_state_RX, 5);
        check("badpid_err", RX_Error, 1);
        m.err = 0;
        cyc(0, 8'h00, 1, 0, 0);
        idle(1);
        check("badpid_idle", {out_state_RX, RX_Error}, 0);
        check("badpid_pid", RX_Packet, 4'h3);

        got_q = {}; v0 = vcount; pl = {};
        repeat (65) pl.push_back(8'($urandom));
        q = mk_data(8'h4B, pl);
        send_pkt(q, -1);
        check("ovf_stores", got_q.size(), 64);
        check("ovf_no_valid", vcount - v0, 0);
        check("ovf_count", byte_count, 64);
        check("ovf_pid", RX_Packet, 4'hB);

        got_q = {};
        pl = {8'h10, 8'h20, 8'h30, 8'h40};
        q = mk_data(8'hC3, pl);
        send_pkt(q, 5);
        check("bf_stores", got_q.size(), 1);
        if (got_q.size() > 0) check("bf_data", got_q[0], 8'h10);

        pl = {}; zc = crc_bytes(pl);
        check("zlp_crc", {zc[0], zc[1]}, 16'h0000);
        v0 = vcount;
        q = {8'h80, 8'hC3, 8'h00, 8'h00};
        send_pkt(q, -1);
        check("zlp_valid", vcount - v0, 1);
        check("zlp_count", byte_count, 0);

`ifdef USB_RX_CRC16_CHECK_EN
        v0 = vcount;
        pl = {8'h01, 8'h02, 8'h03};
        q = mk_data(8'hC3, pl);
        q[4] = q[4] ^ 8'h80;
        send_pkt(q, -1);
        check("crc_bad_no_valid", vcount - v0, 0);
`endif

        cyc(0, 8'h00, 0, 0, 1);
        idle(1);
        m.cnt = 0; m.act = 1;
        cyc(1, 8'h80, 0, 0, 0);
        m.pid = 4'h3;
        cyc(1, 8'hC3, 0, 0, 0);
        cyc(1, 8'h11, 0, 0, 0);
        m.err = 1; m.act = 0;
        cyc(0, 8'h00, 0, 0, 1);
        idle(1);
        check("biterr_state", out_state_RX, 5);
        m.err = 0;
        cyc(0, 8'h00, 1, 0, 0);
        idle(1);

        m.cnt = 0; m.act = 1;
        cyc(1, 8'h80, 0, 0, 0);
        m.pid = 4'hA;
        cyc(1, 8'h5A, 0, 0, 0);
        m.err = 1; m.act = 0;
        cyc(1, 8'h00, 1, 0, 0);
        idle(1);
        check("collide_err", RX_Error, 1);
        m.err = 0;
        cyc(0, 8'h00, 1, 0, 0);
        idle(1);

        m.cnt = 0; m.act = 1;
        cyc(1, 8'h80, 0, 0, 0);
        m.pid = 4'hB;
        cyc(1, 8'h4B, 0, 0, 0);
        cyc(1, 8'hAA, 0, 0, 0);
        cyc(1, 8'hBB, 0, 0, 0);
        m.st = 1; m.d = 8'hAA; m.cnt = 1;
        cyc(1, 8'hCC, 0, 0, 0);
        @(negedge clk);
        #1 rst = 1;
        #1 check("rst_async", {dut_o, out_state_RX}, 0);
        m = '0; nxt = '0;
        rx_byte_valid = 0; rx_eop = 0; rx_bit_error = 0; buffer_full = 0; rx_byte = 0;
        @(posedge clk);
        #1 rst = 0;
        idle(2);

        for (int k = 0; k < 60; k++) begin
            t = $urandom_range(0, 9); bf = -1; pl = {};
            repeat ($urandom_range(0, 8)) pl.push_back(8'($urandom));
            case (t)
                0, 1, 2, 3: begin
                    q = mk_data($urandom_range(0, 1) ? 8'hC3 : 8'h4B, pl);
                    if ($urandom_range(0, 3) == 0) bf = $urandom_range(2, q.size());
                    if ($urandom_range(0, 5) == 0) q[q.size()-1] = q[q.size()-1] ^ 8'h01;
                end
                4: begin
                    q = {8'h80, $urandom_range(0, 1) ? 8'hE1 : 8'h69};
                    repeat ($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 2) q.push_back(8'($urandom));
                end
                5: begin
                    t = $urandom_range(0, 2);
                    q = {8'h80, t == 0 ? 8'hD2 : t == 1 ? 8'h5A : 8'h1E};
                    if ($urandom_range(0, 3) == 0) q.push_back(8'($urandom));
                end
                6: q = {8'($urandom_range(0, 127)), 8'hC3, 8'h00};
                7: q = {8'h80, 8'($urandom)};
                8: begin
                    q = {8'h80, 8'hC3};
                    repeat ($urandom_range(0, 1)) q.push_back(8'($urandom));
                end
                default: q = mk_data(8'hC3, pl);
            endcase
            send_pkt(q, bf);
        end

        idle(3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/usb_rx_packet_fsm.md
Name: usb_rx_packet_fsm

Overview:
Packet-level receive controller for the USB module. It is the counterpart of the TX state machine.
- Consumes decoded bytes from the bit-level front end, which handles NRZI decoding, bit unstuffing and EOP detection.
- Validates SYNC and PID, tracks the packet type, and forwards DATA payload bytes to the RX FIFO with the trailing CRC16 bytes stripped.
- Reports the received PID, completion and errors to the protocol controller.

Parameters:
MAX_DATA_BYTES, 64, maximum payload bytes accepted in a DATA packet (excluding CRC).
SYNC_BYTE, 8'h80, expected first byte as presented by the front end.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
rx_byte_valid  input  1  one-cycle strobe; rx_byte holds a decoded byte
rx_byte  input  8  decoded byte, LSB = first bit on the bus
rx_eop  input  1  one-cycle strobe: EOP detected
rx_bit_error  input  1  one-cycle strobe: stuffing or line error
buffer_full  input  1  RX FIFO cannot accept a byte this cycle
RX_Packet  output  4  PID of the last accepted packet
rx_packet_valid  output  1  one-cycle pulse: packet completed without error
store_rx_data  output  1  one-cycle write strobe to the RX FIFO
rx_data  output  8  payload byte, valid while store_rx_data = 1
byte_count  output  7  payload bytes stored for the current or last packet
RX_Transfer_Active  output  1  high in every state except IDLE_RX and ERROR_RX
RX_Error  output  1  high while in ERROR_RX
out_state_RX  output  3  current state encoding

Behaviour:
- Reset (async, rst=1): state IDLE_RX. All outputs 0. Internal hold registers and hold count cleared.
- Input timing: at most one rx_byte_valid per clock.
- Event priority, highest first:
  - rst
  - rx_bit_error in any non-IDLE state -> ERROR_RX
  - rx_byte_valid and rx_eop in the same cycle -> ERROR_RX
  - single events, per the state rules below
- States: IDLE_RX=0, PID_RX=1, TOKEN_RX=2, DATA_RX=3, EOP_RX=4, ERROR_RX=5, DONE_RX=6.
- IDLE_RX:
  - byte == SYNC_BYTE -> PID_RX; clear byte_count.
  - Any other byte -> ERROR_RX.
  - rx_eop is ignored.
- PID_RX: on a byte, the PID check requires rx_byte[7:4] == ~rx_byte[3:0]; failure -> ERROR_RX.
  - OUT 0001, IN 1001 -> TOKEN_RX.
  - DATA0 0011, DATA1 1011 -> DATA_RX.
  - ACK 0010, NAK 1010, STALL 1110 -> EOP_RX.
  - Any other PID -> ERROR_RX.
  - rx_eop -> ERROR_RX.
  - RX_Packet is updated with rx_byte[3:0] only on a legal PID.
- TOKEN_RX:
  - Counts exactly 2 bytes (address/endpoint/CRC5), then -> EOP_RX. The CRC5 is not checked.
  - rx_eop before the 2nd byte -> ERROR_RX.
- DATA_RX uses a 2-entry delay line (hold0 = newest, hold1 = oldest, hcnt 0..2):
  - On a byte with hcnt == 2: hold1 is emitted (rx_data = hold1, store_rx_data = 1 the next cycle, registered), byte_count increments, then the line shifts.
  - If hcnt == 2 and buffer_full = 1 -> ERROR_RX; nothing is stored.
  - If byte_count == MAX_DATA_BYTES and an emit is required -> ERROR_RX (overflow).
  - rx_eop with hcnt < 2 -> ERROR_RX (short packet).
  - rx_eop with hcnt == 2 -> DONE_RX. The two held bytes are the CRC16 and are never stored.
  - A zero-length DATA packet (SYNC, PID, CRC, CRC, EOP) is legal: byte_count = 0.
- EOP_RX: rx_eop -> DONE_RX; any byte -> ERROR_RX.
- DONE_RX: single cycle; rx_packet_valid = 1; -> IDLE_RX.
- ERROR_RX:
  - RX_Error = 1; stores are suppressed.
  - rx_eop -> IDLE_RX; RX_Error stays high until that transition.
  - RX_Packet retains its last accepted value.
- byte_count holds its value after DONE_RX or ERROR_RX until the next SYNC.
- Latency: the byte that triggers an emit produces store_rx_data exactly 1 cycle after its rx_byte_valid. rx_packet_valid asserts 1 cycle after rx_eop.

Optional Feature:
USB_RX_CRC16_CHECK_EN.
- Defined:
  - A CRC16 register is initialised to 16'hFFFF on PID accept. Polynomial x^16+x^15+x^2+1; bytes are processed LSB-first.
  - Every DATA_RX byte is folded into the CRC, including the CRC bytes.
  - At rx_eop the register must equal residual 16'h800D; otherwise -> ERROR_RX instead of DONE_RX.
  - Adds a check of at most one cycle; rx_packet_valid latency remains 1 cycle.
- Undefined: no CRC logic; CRC bytes are silently dropped.

Test Plan:
- ACK: bytes 80, D2, then rx_eop -> RX_Packet=0010; rx_packet_valid pulses 1 cycle after eop; store_rx_data never asserts.
- DATA0 payload 01 02 03 followed by a correct CRC, then eop -> exactly 3 stores, rx_data = 01, 02, 03 in order; byte_count=3; rx_packet_valid=1; RX_Packet=0011.
- Bad PID byte 8'h33 after sync -> ERROR_RX and RX_Error=1; on rx_eop -> IDLE_RX with RX_Error=0; RX_Packet unchanged.
- DATA1 with 65 payload bytes plus CRC (MAX_DATA_BYTES=64) -> 64 stores, then ERROR_RX on the 65th emit; no rx_packet_valid.
- buffer_full=1 during a DATA0 emit -> ERROR_RX; no store that cycle. Separately, rst asserted mid-DATA_RX -> immediate IDLE_RX with all outputs 0.
- With USB_RX_CRC16_CHECK_EN: corrupt one CRC byte -> ERROR_RX at eop, no rx_packet_valid. Zero-length DATA0 80 C3 00 00 then eop -> rx_packet_valid=1, byte_count=0.
